// File: rtl/kernel_stream_ctrl_if.sv
// Control-only stream handshake bundle between the source/sink logic and kernel_stream_ctrl.
// The master side drives job start and stream inputs; the slave side is the controller.
interface kernel_stream_ctrl_if #(
  parameter int CNTW = 16
);
  logic            start;
  logic [CNTW-1:0] nitems;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic            k_stall;
  logic            out_valid;
  logic            out_ready;
  logic [CNTW-1:0] in_cnt;
  logic [CNTW-1:0] out_cnt;

  modport master (
    output start, nitems, in_valid, out_ready,
    input  busy, done, in_ready, k_stall, out_valid, in_cnt, out_cnt
  );

  modport slave (
    input  start, nitems, in_valid, out_ready,
    output busy, done, in_ready, k_stall, out_valid, in_cnt, out_cnt
  );
endinterface

// File: rtl/kernel_stream_ctrl.sv
// Job sequencer for a fixed-latency, stall-gated streaming kernel: admits NITEMS elements,
// tracks them through the pipe with a valid shift register, drains, then pulses done.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; kernel held stalled
//   S_RUN   | accepting upstream elements until nitems have been taken
//   S_DRAIN | no more input; flushing in-flight elements downstream
//   S_DONE  | one-cycle done pulse, counters keep final values
module kernel_stream_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  kernel_stream_ctrl_if.slave  bus
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PIPE_LAT-1:0] r_vpipe;
  logic [CNTW-1:0]     r_in_cnt;
  logic [CNTW-1:0]     r_out_cnt;
  logic [CNTW-1:0]     r_nitems;
  logic                r_busy;

  logic w_active;
  logic w_adv;
  logic w_in_ready;
  logic w_acc;
  logic w_out_valid;
  logic w_dlv;
  logic w_start_ok;

  // The kernel only advances when the element at its output is not being held back.
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_adv       = w_active && !(r_vpipe[PIPE_LAT-1] && !bus.out_ready);
  assign w_in_ready  = (r_state == S_RUN) && w_adv && (r_in_cnt < r_nitems);
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_out_valid = w_active && r_vpipe[PIPE_LAT-1];
  assign w_dlv       = w_out_valid && bus.out_ready;
  assign w_start_ok  = (r_state == S_IDLE) && bus.start;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.k_stall   = !w_adv;
  assign bus.busy      = r_busy;
  assign bus.done      = (r_state == S_DONE);
  assign bus.in_cnt    = r_in_cnt;
  assign bus.out_cnt   = r_out_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.nitems != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_acc && (r_in_cnt == r_nitems - ONE)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_dlv && (r_out_cnt == r_nitems - ONE)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_nitems  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      if (w_adv) begin
        r_vpipe <= (r_vpipe << 1) | PIPE_LAT'(w_acc);
      end
      if (w_start_ok) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        if (bus.nitems != '0) begin
          r_nitems <= bus.nitems;
        end
      end else begin
        if (w_acc) begin
          r_in_cnt <= r_in_cnt + ONE;
        end
        if (w_dlv) begin
          r_out_cnt <= r_out_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Bench for kernel_stream_ctrl: directed job scenarios plus randomized jobs, every cycle
// compared against an element-age queue model of the stall-gated pipeline.
module tb_kernel_stream_ctrl;
  localparam int P  = 4;
  localparam int CW = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kernel_stream_ctrl_if #(.CNTW(CW)) bus ();

  kernel_stream_ctrl #(.PIPE_LAT(P), .CNTW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: job phase, counters, and the advance-age of every element inside the kernel.
  int m_st;
  int q[$];
  int m_in, m_out, m_n;
  bit m_busy;

  logic [63:0] lg_ir, lg_ov, lg_ks, lg_done, lg_busy, lg_acc, lg_dlv;
  int cyc, n_acc, n_dlv, n_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE;
    q.delete();
    m_in = 0; m_out = 0; m_n = 0; m_busy = 1'b0;
  endtask

  task automatic log_clear();
    lg_ir = '0; lg_ov = '0; lg_ks = '0; lg_done = '0; lg_busy = '0; lg_acc = '0; lg_dlv = '0;
    cyc = 0; n_acc = 0; n_dlv = 0; n_done = 0;
  endtask

  task automatic step(input bit s, input int n, input bit iv, input bit ordy);
    bit act, full, adv, e_ir, e_ov, acc, dlv;
    int nx;
    @(negedge clk);
    bus.start     = s;
    bus.nitems    = CW'(n);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    #1;
    act  = (m_st == M_RUN) || (m_st == M_DRAIN);
    full = (q.size() > 0) && (q[0] == P);
    adv  = act && !(full && !ordy);
    e_ir = (m_st == M_RUN) && adv && (m_in < m_n);
    e_ov = act && full;
    chk("in_ready",  bus.in_ready,  e_ir);
    chk("out_valid", bus.out_valid, e_ov);
    chk("k_stall",   bus.k_stall,   !adv);
    chk("done",      bus.done,      m_st == M_DONE);
    chk("busy",      bus.busy,      m_busy);
    chk("in_cnt",    bus.in_cnt,    m_in);
    chk("out_cnt",   bus.out_cnt,   m_out);
    acc = iv && bus.in_ready;
    dlv = bus.out_valid && ordy;
    if (cyc < 64) begin
      lg_ir[cyc] = bus.in_ready; lg_ov[cyc] = bus.out_valid; lg_ks[cyc] = bus.k_stall;
      lg_done[cyc] = bus.done; lg_busy[cyc] = bus.busy; lg_acc[cyc] = acc; lg_dlv[cyc] = dlv;
    end
    n_acc += int'(acc); n_dlv += int'(dlv); n_done += int'(bus.done);
    acc = iv && e_ir;
    dlv = e_ov && ordy;
    @(posedge clk);
    if (adv) begin
      if (dlv) void'(q.pop_front());
      foreach (q[i]) q[i]++;
      if (acc) q.push_back(1);
    end
    nx = m_st;
    case (m_st)
      M_IDLE: if (s) begin
        m_in = 0; m_out = 0;
        if (n != 0) begin m_n = n; nx = M_RUN; end
        else nx = M_DONE;
      end
      M_RUN: begin
        if (acc) begin m_in++; if (m_in == m_n) nx = M_DRAIN; end
        if (dlv) m_out++;
      end
      M_DRAIN: if (dlv) begin m_out++; if (m_out == m_n) nx = M_DONE; end
      default: nx = M_IDLE;
    endcase
    m_st   = nx;
    m_busy = (nx == M_RUN) || (nx == M_DRAIN);
    cyc++;
  endtask

  initial begin
    int n, pv, pr, k;
    bus.start = 1'b0; bus.nitems = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    log_clear();

    #12;
    chk("rst_k_stall",   bus.k_stall,   1'b1);
    chk("rst_busy",      bus.busy,      1'b0);
    chk("rst_done",      bus.done,      1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_cnt",    bus.in_cnt,    0);
    chk("rst_out_cnt",   bus.out_cnt,   0);
    #1 rst = 1'b0;

    // Full-rate job
    log_clear();
    step(1'b1, 8, 1'b1, 1'b1);
    repeat (20) step(1'b0, 0, 1'b1, 1'b1);
    chk("t1_in_ready",  lg_ir,   rng(1, 8));
    chk("t1_out_valid", lg_ov,   rng(5, 12));
    chk("t1_done",      lg_done, rng(13, 13));
    chk("t1_k_stall",   lg_ks,   rng(0, 0) | rng(13, 20));
    chk("t1_out_cnt",   bus.out_cnt, 8);

    // Backpressure in cycles 7-9
    log_clear();
    for (int c = 0; c <= 22; c++) step(c == 0, 8, 1'b1, !(c >= 7 && c <= 9));
    chk("t2_k_stall",  lg_ks,   rng(0, 0) | rng(7, 9) | rng(16, 22));
    chk("t2_in_ready", lg_ir,   rng(1, 6) | rng(10, 11));
    chk("t2_dlv",      lg_dlv,  rng(5, 6) | rng(10, 15));
    chk("t2_done",     lg_done, rng(16, 16));
    chk("t2_n_dlv",    n_dlv, 8);

    // Alternating in_valid bubbles
    log_clear();
    for (int c = 0; c <= 15; c++) step(c == 0, 4, (c % 2) == 1, 1'b1);
    chk("t3_acc",       lg_acc,  rng(1, 1) | rng(3, 3) | rng(5, 5) | rng(7, 7));
    chk("t3_out_valid", lg_ov,   rng(5, 5) | rng(7, 7) | rng(9, 9) | rng(11, 11));
    chk("t3_done",      lg_done, rng(12, 12));

    // Empty job
    log_clear();
    for (int c = 0; c <= 5; c++) step(c == 0, 0, 1'b1, 1'b1);
    chk("t4_in_ready", lg_ir,   64'd0);
    chk("t4_busy",     lg_busy, 64'd0);
    chk("t4_done",     lg_done, rng(1, 1));

    // Start re-pulsed mid-job is ignored
    log_clear();
    for (int c = 0; c <= 16; c++) step(c == 0 || c == 3, (c == 3) ? 3 : 5, 1'b1, 1'b1);
    chk("t5_out_cnt", bus.out_cnt, 5);
    chk("t5_n_dlv",   n_dlv, 5);
    chk("t5_done",    lg_done, rng(10, 10));

    // Reset during DRAIN with two elements still in flight
    log_clear();
    step(1'b1, 4, 1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) step(1'b0, 0, 1'b1, 1'b1);
    chk("t6_inflight_ov", bus.out_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_k_stall",   bus.k_stall,   1'b1);
    chk("t6_rst_busy",      bus.busy,      1'b0);
    chk("t6_rst_out_valid", bus.out_valid, 1'b0);
    chk("t6_rst_in_ready",  bus.in_ready,  1'b0);
    chk("t6_rst_done",      bus.done,      1'b0);
    chk("t6_rst_out_cnt",   bus.out_cnt,   0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_hold_done", bus.done, 1'b0);
    chk("t6_no_done",       n_done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    log_clear();
    step(1'b1, 2, 1'b1, 1'b1);
    repeat (10) step(1'b0, 0, 1'b1, 1'b1);
    chk("t6_after_out_cnt", bus.out_cnt, 2);
    chk("t6_after_done",    n_done, 1);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      n  = $urandom_range(0, 12);
      pv = $urandom_range(40, 100);
      pr = $urandom_range(40, 100);
      log_clear();
      step(1'b1, n, $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
      k = 0;
      while (n_done == 0 && k < 300) begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 20),
             $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
        k++;
      end
      chk("rnd_done_seen", n_done, 1);
      chk("rnd_n_acc",     n_acc, n);
      chk("rnd_n_dlv",     n_dlv, n);
      chk("rnd_out_cnt",   bus.out_cnt, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
